// File: rtl/rssi_ddr_rdagent_pkg.sv
// Shared constants and state encoding for the RSSI DDR read agent.
// No logic; consumed by the agent and its FIFO.
// Imported with data_packet::*.
package data_packet;

    // Read agent FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CMD   = 2'd1,
        ST_DATA  = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    // Depth of the read-data FIFO between DDR and the calibration consumer
    localparam int FIFO_DEPTH = 4;

    // Word address to byte address shift (8-byte DDR words)
    localparam int BYTE_SHIFT = 3;

endpackage

// File: rtl/rssi_sync_fifo.sv
// Synchronous FIFO with registered read data and registered empty flag.
// Latency: push visible (empty low) next cycle; pop data valid one cycle after pop.
// Backpressure: none; push while full without pop is dropped and flagged on ovf.
module rssi_sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic             empty,
    output logic             ovf
);

    // Pointers wrap naturally; DEPTH is expected to be a power of two.
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_nxt;
    logic             full;
    logic             do_pop;
    logic             do_push;

    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && (count != '0);
    // A pop frees a slot in the same cycle, so a full FIFO still accepts the push.
    assign do_push = push && (!full || do_pop);
    assign ovf     = push && full && !pop;

    // Next occupancy from accepted push/pop
    always_comb begin
        count_nxt = count;
        if (do_push && !do_pop) begin
            count_nxt = count + CW'(1);
        end else if (!do_push && do_pop) begin
            count_nxt = count - CW'(1);
        end
    end

    // Storage write; contents need no reset
    always_ff @(posedge i_clk) begin
        if (do_push) begin
            mem[wptr] <= push_dat;
        end
    end

    // Pointers, occupancy, registered read data and empty flag
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
            pop_dat <= '0;
            empty   <= 1'b1;
        end else begin
            if (do_push) begin
                wptr <= wptr + AW'(1);
            end
            if (do_pop) begin
                rptr    <= rptr + AW'(1);
                pop_dat <= mem[rptr];
            end
            count <= count_nxt;
            empty <= (count_nxt == '0);
        end
    end

endmodule

// File: rtl/rssi_ddr_rdagent.sv
// DDR read agent: one command per request, BURST_LEN beats into a 4-word FIFO.
// Latency: command one cycle after request; beats pushed the cycle they arrive.
// Backpressure: command held until i_cmd_rdy; requests while busy dropped and flagged.
module rssi_ddr_rdagent
    import data_packet::*;
#(
    parameter int DDR_AW    = 32,
    parameter int DDR_DW    = 64,
    parameter int BURST_LEN = 2,
    parameter int TIMEOUT   = 1023
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_ddr_rden,
    input  logic [DDR_AW-1:0] i_rdddr_addr_base,
    output logic              o_cmd_en,
    output logic [DDR_AW-1:0] o_cmd_addr,
    output logic [3:0]        o_cmd_bl,
    input  logic              i_cmd_rdy,
    input  logic              i_rd_valid,
    input  logic [DDR_DW-1:0] i_rd_data,
    input  logic              i_fifo_rden,
    output logic [DDR_DW-1:0] o_fifo_rddata,
    output logic              o_fifo_empty,
    output logic              o_busy,
    input  logic              i_err_clr,
    output logic              o_err_timeout,
    output logic              o_err_ovf,
    output logic              o_err_reqdrop
);

    localparam int BW = $clog2(BURST_LEN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    state_t          state;
    logic [BW-1:0]   beat_cnt;
    logic [TW-1:0]   to_cnt;
    logic            last_beat;
    logic            timeout_hit;
    logic            fifo_push;
    logic [DDR_DW-1:0] fifo_push_dat;
    logic            fifo_ovf;

    assign o_cmd_bl    = 4'(BURST_LEN);
    assign last_beat   = (beat_cnt == BW'(BURST_LEN - 1));
    assign timeout_hit = (state == ST_DATA) && !i_rd_valid && (to_cnt == TW'(TIMEOUT - 1));

    // Real beats only while waiting for data; zero padding while flushing.
    assign fifo_push     = ((state == ST_DATA) && i_rd_valid) || (state == ST_FLUSH);
    assign fifo_push_dat = (state == ST_FLUSH) ? '0 : i_rd_data;

    // Request FSM with registered command and busy outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= ST_IDLE;
            o_cmd_en   <= 1'b0;
            o_cmd_addr <= '0;
            o_busy     <= 1'b0;
            beat_cnt   <= '0;
            to_cnt     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_ddr_rden) begin
                        o_cmd_addr <= i_rdddr_addr_base << BYTE_SHIFT;
                        o_cmd_en   <= 1'b1;
                        o_busy     <= 1'b1;
                        state      <= ST_CMD;
                    end
                end
                ST_CMD: begin
                    if (i_cmd_rdy) begin
                        o_cmd_en <= 1'b0;
                        beat_cnt <= '0;
                        to_cnt   <= '0;
                        state    <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (i_rd_valid) begin
                        to_cnt <= '0;
                        if (last_beat) begin
                            beat_cnt <= '0;
                            o_busy   <= 1'b0;
                            state    <= ST_IDLE;
                        end else begin
                            beat_cnt <= beat_cnt + BW'(1);
                        end
                    end else if (timeout_hit) begin
                        state <= ST_FLUSH;
                    end else begin
                        to_cnt <= to_cnt + TW'(1);
                    end
                end
                ST_FLUSH: begin
                    // Pad out the burst so the consumer always gets BURST_LEN words.
                    if (last_beat) begin
                        beat_cnt <= '0;
                        o_busy   <= 1'b0;
                        state    <= ST_IDLE;
                    end else begin
                        beat_cnt <= beat_cnt + BW'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Sticky error flags; a set in the same cycle overrides a clear
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_err_timeout <= 1'b0;
            o_err_ovf     <= 1'b0;
            o_err_reqdrop <= 1'b0;
        end else begin
            if (timeout_hit)           o_err_timeout <= 1'b1;
            else if (i_err_clr)        o_err_timeout <= 1'b0;
            if (fifo_ovf)              o_err_ovf     <= 1'b1;
            else if (i_err_clr)        o_err_ovf     <= 1'b0;
            if (i_ddr_rden && o_busy)  o_err_reqdrop <= 1'b1;
            else if (i_err_clr)        o_err_reqdrop <= 1'b0;
        end
    end

    rssi_sync_fifo #(
        .WIDTH (DDR_DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .push     (fifo_push),
        .push_dat (fifo_push_dat),
        .pop      (i_fifo_rden),
        .pop_dat  (o_fifo_rddata),
        .empty    (o_fifo_empty),
        .ovf      (fifo_ovf)
    );

endmodule

// File: tb/tb_rssi_ddr_rdagent.sv
// Directed bench for rssi_ddr_rdagent: table of requests plus corner sequences.
// Inputs change 1 ns after the rising edge; outputs are sampled at the same point.
// Expected values are hand-computed constants.
module tb_rssi_ddr_rdagent;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ddr_rden;
    logic [31:0] addr_base;
    logic        cmd_en;
    logic [31:0] cmd_addr;
    logic [3:0]  cmd_bl;
    logic        cmd_rdy;
    logic        rd_valid;
    logic [63:0] rd_data;
    logic        fifo_rden;
    logic [63:0] fifo_rddata;
    logic        fifo_empty;
    logic        busy;
    logic        err_clr;
    logic        err_timeout;
    logic        err_ovf;
    logic        err_reqdrop;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] addr;
        int          dly;
        int          gap;
        logic [63:0] b0;
        logic [63:0] b1;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t vecs [4];

    always #5 clk = ~clk;

    rssi_ddr_rdagent dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_ddr_rden        (ddr_rden),
        .i_rdddr_addr_base (addr_base),
        .o_cmd_en          (cmd_en),
        .o_cmd_addr        (cmd_addr),
        .o_cmd_bl          (cmd_bl),
        .i_cmd_rdy         (cmd_rdy),
        .i_rd_valid        (rd_valid),
        .i_rd_data         (rd_data),
        .i_fifo_rden       (fifo_rden),
        .o_fifo_rddata     (fifo_rddata),
        .o_fifo_empty      (fifo_empty),
        .o_busy            (busy),
        .i_err_clr         (err_clr),
        .o_err_timeout     (err_timeout),
        .o_err_ovf         (err_ovf),
        .o_err_reqdrop     (err_reqdrop)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    // Request, hold the command for dly cycles (optionally with stray beats), then accept
    task automatic issue(input logic [31:0] a, input int dly, input logic [31:0] exp_a, input bit stray);
        ddr_rden  = 1'b1;
        addr_base = a;
        tick();
        ddr_rden  = 1'b0;
        addr_base = 32'hDEAD_BEEF;
        for (int i = 0; i < dly; i++) begin
            chk("cmd_en_wait", cmd_en, 1);
            chk("cmd_addr_wait", cmd_addr, exp_a);
            rd_valid = stray;
            rd_data  = 64'hBAD0_0000 + 64'(i);
            tick();
        end
        rd_valid = 1'b0;
        cmd_rdy  = 1'b1;
        chk("cmd_en_accept", cmd_en, 1);
        chk("cmd_addr_accept", cmd_addr, exp_a);
        tick();
        cmd_rdy = 1'b0;
        chk("cmd_en_after", cmd_en, 0);
    endtask

    task automatic beat(input logic [63:0] d);
        rd_valid = 1'b1;
        rd_data  = d;
        tick();
        rd_valid = 1'b0;
    endtask

    task automatic pop_chk(input string nm, input logic [63:0] exp);
        fifo_rden = 1'b1;
        tick();
        fifo_rden = 1'b0;
        chk(nm, fifo_rddata, exp);
    endtask

    task automatic clear_errs();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;

        vecs[0] = '{32'h0000_8005, 3, 0, 64'hAAAA_0000_0000_000A, 64'hBBBB_0000_0000_000B, 32'h0004_0028};
        vecs[1] = '{32'h0000_0000, 0, 2, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 32'h0000_0000};
        vecs[2] = '{32'h1FFF_FFFF, 1, 5, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001, 32'hFFFF_FFF8};
        vecs[3] = '{32'h3000_0001, 2, 1, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 32'h8000_0008};

        rst_n     = 1'b0;
        ddr_rden  = 1'b0;
        addr_base = '0;
        cmd_rdy   = 1'b0;
        rd_valid  = 1'b0;
        rd_data   = '0;
        fifo_rden = 1'b0;
        err_clr   = 1'b0;
        tick();
        tick();

        chk("rst_cmd_en", cmd_en, 0);
        chk("rst_cmd_addr", cmd_addr, 0);
        chk("rst_rddata", fifo_rddata, 0);
        chk("rst_empty", fifo_empty, 1);
        chk("rst_busy", busy, 0);
        chk("rst_err_timeout", err_timeout, 0);
        chk("rst_err_ovf", err_ovf, 0);
        chk("rst_err_reqdrop", err_reqdrop, 0);
        chk("cmd_bl", cmd_bl, 2);
        rst_n = 1'b1;
        tick();

        // Table of requests: address translation, command hold, beat gaps, pop order
        for (int v = 0; v < 4; v++) begin
            issue(vecs[v].addr, vecs[v].dly, vecs[v].exp_addr, 1'b1);
            chk("busy_data", busy, 1);
            beat(vecs[v].b0);
            chk("empty_after_push", fifo_empty, 0);
            repeat (vecs[v].gap) tick();
            beat(vecs[v].b1);
            chk("busy_done", busy, 0);
            pop_chk("pop_b0", vecs[v].b0);
            pop_chk("pop_b1", vecs[v].b1);
            chk("empty_drained", fifo_empty, 1);
        end

        // Request during DATA is dropped; set wins over a same-cycle clear
        issue(32'h20, 0, 32'h100, 1'b0);
        ddr_rden  = 1'b1;
        addr_base = 32'h999;
        err_clr   = 1'b1;
        tick();
        ddr_rden = 1'b0;
        err_clr  = 1'b0;
        chk("reqdrop_set", err_reqdrop, 1);
        beat(64'h1);
        beat(64'h2);
        chk("reqdrop_busy_done", busy, 0);
        for (int i = 0; i < 4; i++) begin
            chk("reqdrop_no_cmd", cmd_en, 0);
            tick();
        end
        pop_chk("reqdrop_pop0", 64'h1);
        pop_chk("reqdrop_pop1", 64'h2);
        chk("reqdrop_empty", fifo_empty, 1);
        clear_errs();
        chk("reqdrop_cleared", err_reqdrop, 0);

        // No data after command acceptance: timeout then zero padding
        issue(32'h40, 0, 32'h200, 1'b0);
        n = 0;
        while (!err_timeout && n < 2000) begin
            tick();
            n++;
        end
        chk("timeout_cycles", 64'(n), 1023);
        chk("timeout_busy_flush", busy, 1);
        tick();
        tick();
        chk("timeout_busy_done", busy, 0);
        chk("timeout_empty", fifo_empty, 0);
        pop_chk("timeout_pad0", 64'h0);
        pop_chk("timeout_pad1", 64'h0);
        chk("timeout_drained", fifo_empty, 1);
        chk("timeout_sticky", err_timeout, 1);
        clear_errs();
        chk("timeout_cleared", err_timeout, 0);

        // Overflow: six words offered to a four-deep FIFO with no pops
        issue(32'h100, 0, 32'h800, 1'b0);
        beat(64'hC0);
        beat(64'hC1);
        issue(32'h101, 0, 32'h808, 1'b0);
        beat(64'hC2);
        beat(64'hC3);
        chk("ovf_not_yet", err_ovf, 0);
        issue(32'h102, 0, 32'h810, 1'b0);
        beat(64'hC4);
        chk("ovf_set", err_ovf, 1);
        beat(64'hC5);
        pop_chk("ovf_pop0", 64'hC0);
        pop_chk("ovf_pop1", 64'hC1);
        pop_chk("ovf_pop2", 64'hC2);
        pop_chk("ovf_pop3", 64'hC3);
        chk("ovf_drained", fifo_empty, 1);
        clear_errs();
        chk("ovf_cleared", err_ovf, 0);

        // Full FIFO with simultaneous push and pop keeps four words, no overflow
        issue(32'h200, 0, 32'h1000, 1'b0);
        beat(64'hD0);
        beat(64'hD1);
        issue(32'h201, 0, 32'h1008, 1'b0);
        beat(64'hD2);
        beat(64'hD3);
        issue(32'h202, 0, 32'h1010, 1'b0);
        rd_valid  = 1'b1;
        rd_data   = 64'hE0;
        fifo_rden = 1'b1;
        tick();
        chk("full_pp_pop0", fifo_rddata, 64'hD0);
        chk("full_pp_ovf0", err_ovf, 0);
        rd_data = 64'hE1;
        tick();
        rd_valid  = 1'b0;
        fifo_rden = 1'b0;
        chk("full_pp_pop1", fifo_rddata, 64'hD1);
        chk("full_pp_ovf1", err_ovf, 0);
        pop_chk("full_pp_pop2", 64'hD2);
        pop_chk("full_pp_pop3", 64'hD3);
        pop_chk("full_pp_pop4", 64'hE0);
        chk("full_pp_not_empty", fifo_empty, 0);
        pop_chk("full_pp_pop5", 64'hE1);
        chk("full_pp_empty", fifo_empty, 1);

        // Reset after the first beat abandons the burst; late beat is discarded
        issue(32'h50, 0, 32'h280, 1'b0);
        beat(64'hAA);
        chk("midrst_pushed", fifo_empty, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_cmd_en", cmd_en, 0);
        chk("midrst_cmd_addr", cmd_addr, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_empty", fifo_empty, 1);
        chk("midrst_rddata", fifo_rddata, 0);
        chk("midrst_errs", {err_timeout, err_ovf, err_reqdrop}, 0);
        tick();
        rst_n = 1'b1;
        beat(64'hBB);
        tick();
        chk("late_beat_empty", fifo_empty, 1);
        chk("late_beat_busy", busy, 0);
        pop_chk("pop_on_empty", 64'h0);
        chk("pop_on_empty_flag", fifo_empty, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
